// File: rtl/score_pkg.sv
// Shared types and defaults for the score keeper.
// Holds judge FSM states, note encoding and BCD sizing helpers.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_JUDGE,
        S_CONVERT
    } state_t;

    localparam logic [2:0] NOTE_REST = 3'd0;

    localparam int DEF_POINTS      = 10;
    localparam int DEF_STREAK_STEP = 8;
    localparam int DEF_MAX_MULT    = 4;
    localparam int DEF_SCORE_W     = 16;

    // ceil(w * log10(2)) in fixed point
    function automatic int bcdDigits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    localparam int BCD_DIGITS = bcdDigits(DEF_SCORE_W);

endpackage

// File: rtl/score_keeper_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter.
// One bit per cycle; done pulses once the last shift has landed.
module bin2bcd_seq #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic           clear,
    input  logic [W-1:0]   bin,
    output logic [4*D-1:0] bcd,
    output logic           done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   sh;
    logic [4*D-1:0] acc;
    logic [4*D-1:0] adj;
    logic [CW-1:0]  cnt;
    logic           busy;

    always_comb begin
        adj = acc;
        for (int i = 0; i < D; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= bin;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= {adj[4*D-2:0], sh[W-1]};
                sh  <= {sh[W-2:0], 1'b0};
                cnt <= cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = acc;

endmodule

// File: rtl/score_keeper.sv
// Beat judge, score/streak/multiplier keeper and BCD front end.
// SCORE_MISS_PENALTY_EN: a miss also subtracts POINTS, floored at 0.
module score_keeper
    import score_pkg::*;
#(
    parameter int POINTS      = DEF_POINTS,
    parameter int STREAK_STEP = DEF_STREAK_STEP,
    parameter int MAX_MULT    = DEF_MAX_MULT,
    parameter int SCORE_W     = DEF_SCORE_W,
    localparam int NDIG       = bcdDigits(SCORE_W)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                songDone,
    input  logic                clearScore,
    input  logic                addScore,
    input  logic                changeScore,
    input  logic [2:0]          expectedNote,
    input  logic [2:0]          playerNote,
    input  logic                playerValid,
    output logic [SCORE_W-1:0]  score,
    output logic [7:0]          streak,
    output logic [2:0]          multiplier,
    output logic [7:0]          misses,
    output logic                hit,
    output logic                miss,
    output logic [4*NDIG-1:0]   scoreBcd,
    output logic                bcdValid
);

    state_t               state;
    logic                 judged;
    logic [2:0]           jExp;
    logic                 jHit;
    logic                 pending;
    logic [2:0]           pExp;
    logic                 pHit;
    logic                 strikeSeen;
    logic [2:0]           strikeNote;
    logic                 accept;
    logic                 curHit;
    logic                 startConv;
    logic                 convDone;
    logic [4*NDIG-1:0]    bcdOut;
    logic [7:0]           streakInc;
    logic [7:0]           missInc;
    logic [2:0]           multHit;
    logic [SCORE_W:0]     sum;
    logic [SCORE_W-1:0]   scoreHit;
    logic [SCORE_W-1:0]   scoreMiss;

    assign accept    = addScore && !songDone;
    assign curHit    = strikeSeen && (strikeNote == expectedNote);
    assign startConv = (state == S_JUDGE) && judged
                     && changeScore && !clearScore;

    assign streakInc = (streak == 8'hFF) ? streak : streak + 8'd1;
    assign missInc   = (misses == 8'hFF) ? misses : misses + 8'd1;

    always_comb begin
        int q;
        q = int'(streakInc) / STREAK_STEP + 1;
        if (q > MAX_MULT)
            q = MAX_MULT;
        multHit = 3'(q);
    end

    assign sum       = {1'b0, score}
                     + (SCORE_W+1)'(POINTS * int'(multHit));
    assign scoreHit  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    assign scoreMiss = (score > SCORE_W'(POINTS))
                     ? score - SCORE_W'(POINTS) : '0;

    bin2bcd_seq #(
        .W (SCORE_W),
        .D (NDIG)
    ) u_bcd (
        .clock  (clock),
        .resetn (resetn),
        .start  (startConv),
        .clear  (clearScore),
        .bin    (score),
        .bcd    (bcdOut),
        .done   (convDone)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            judged     <= 1'b0;
            jExp       <= NOTE_REST;
            jHit       <= 1'b0;
            pending    <= 1'b0;
            pExp       <= NOTE_REST;
            pHit       <= 1'b0;
            strikeSeen <= 1'b0;
            strikeNote <= NOTE_REST;
            score      <= '0;
            streak     <= '0;
            multiplier <= 3'd1;
            misses     <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            scoreBcd   <= '0;
            bcdValid   <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;

            // a strike coincident with addScore opens the next beat
            if (clearScore) begin
                strikeSeen <= 1'b0;
                strikeNote <= NOTE_REST;
            end else if (accept) begin
                strikeSeen <= playerValid;
                strikeNote <= playerNote;
            end else if (playerValid && !strikeSeen) begin
                strikeSeen <= 1'b1;
                strikeNote <= playerNote;
            end

            if (clearScore) begin
                state      <= S_IDLE;
                judged     <= 1'b0;
                pending    <= 1'b0;
                score      <= '0;
                streak     <= '0;
                multiplier <= 3'd1;
                misses     <= '0;
                scoreBcd   <= '0;
                bcdValid   <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (pending && !songDone) begin
                            state   <= S_JUDGE;
                            judged  <= 1'b0;
                            jExp    <= pExp;
                            jHit    <= pHit;
                            pending <= accept;
                            pExp    <= expectedNote;
                            pHit    <= curHit;
                        end else if (accept) begin
                            state  <= S_JUDGE;
                            judged <= 1'b0;
                            jExp   <= expectedNote;
                            jHit   <= curHit;
                        end
                    end
                    S_JUDGE: begin
                        if (accept && !pending) begin
                            pending <= 1'b1;
                            pExp    <= expectedNote;
                            pHit    <= curHit;
                        end
                        if (!judged) begin
                            judged   <= 1'b1;
                            bcdValid <= 1'b0;
                            if (!songDone && jExp != NOTE_REST) begin
                                if (jHit) begin
                                    hit        <= 1'b1;
                                    streak     <= streakInc;
                                    multiplier <= multHit;
                                    score      <= scoreHit;
                                end else begin
                                    miss       <= 1'b1;
                                    streak     <= '0;
                                    multiplier <= 3'd1;
                                    misses     <= missInc;
`ifdef SCORE_MISS_PENALTY_EN
                                    score      <= scoreMiss;
`endif
                                end
                            end
                        end else if (changeScore) begin
                            state <= S_CONVERT;
                        end
                    end
                    S_CONVERT: begin
                        if (accept && !pending) begin
                            pending <= 1'b1;
                            pExp    <= expectedNote;
                            pHit    <= curHit;
                        end
                        if (convDone) begin
                            scoreBcd <= bcdOut;
                            bcdValid <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef SCORE_MISS_PENALTY_EN
    logic unusedMiss;
    assign unusedMiss = ^scoreMiss;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, corner
// sequences and random beats against a behavioural score model.
module tb_score_keeper;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        songDone = 1'b0;
    logic        clearScore = 1'b0;
    logic        addScore = 1'b0;
    logic        changeScore = 1'b1;
    logic [2:0]  expectedNote = 3'd0;
    logic [2:0]  playerNote = 3'd0;
    logic        playerValid = 1'b0;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [7:0]  misses;
    logic        hit;
    logic        miss;
    logic [19:0] scoreBcd;
    logic        bcdValid;

    score_keeper dut (
        .clock        (clock),
        .resetn       (resetn),
        .songDone     (songDone),
        .clearScore   (clearScore),
        .addScore     (addScore),
        .changeScore  (changeScore),
        .expectedNote (expectedNote),
        .playerNote   (playerNote),
        .playerValid  (playerValid),
        .score        (score),
        .streak       (streak),
        .multiplier   (multiplier),
        .misses       (misses),
        .hit          (hit),
        .miss         (miss),
        .scoreBcd     (scoreBcd),
        .bcdValid     (bcdValid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    int mScore, mStreak, mMult, mMisses;

    typedef struct {
        logic [2:0] exp;
        int         ns;
        logic [2:0] n1;
        logic [2:0] n2;
        bit         eHit;
        bit         eMiss;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mScore = 0;
        mStreak = 0;
        mMult = 1;
        mMisses = 0;
    endtask

    task automatic modelBeat(input logic [2:0] exp, input bit struck,
                             input logic [2:0] note,
                             output bit eh, output bit em);
        eh = 0;
        em = 0;
        if (exp == 3'd0) return;
        if (struck && note == exp) begin
            eh = 1;
            mStreak = (mStreak < 255) ? mStreak + 1 : 255;
            mMult = 1 + mStreak / 8;
            if (mMult > 4) mMult = 4;
            mScore = mScore + 10 * mMult;
            if (mScore > 65535) mScore = 65535;
        end else begin
            em = 1;
            mStreak = 0;
            mMult = 1;
            if (mMisses < 255) mMisses++;
`ifdef SCORE_MISS_PENALTY_EN
            mScore = (mScore >= 10) ? mScore - 10 : 0;
`endif
        end
    endtask

    function automatic logic [19:0] bcdOf(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic strike(input logic [2:0] n);
        playerValid = 1'b1;
        playerNote = n;
        @(negedge clock);
        playerValid = 1'b0;
    endtask

    // leaves the caller at the negedge where judge results are visible
    task automatic applyBeat(input logic [2:0] exp, input int ns,
                             input logic [2:0] n1, input logic [2:0] n2);
        if (ns > 0) strike(n1);
        if (ns > 1) strike(n2);
        addScore = 1'b1;
        expectedNote = exp;
        @(negedge clock);
        addScore = 1'b0;
        @(negedge clock);
    endtask

    task automatic checkState(input string tag);
        chk({tag, " score"}, 32'(score), 32'(mScore));
        chk({tag, " streak"}, 32'(streak), 32'(mStreak));
        chk({tag, " mult"}, 32'(multiplier), 32'(mMult));
        chk({tag, " misses"}, 32'(misses), 32'(mMisses));
    endtask

    task automatic waitValid(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (bcdValid) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic checkBcd(input string tag);
        bit ok;
        waitValid(ok);
        chk({tag, " bcdValid"}, 32'(ok), 32'd1);
        chk({tag, " bcd"}, 32'(scoreBcd), 32'(bcdOf(mScore)));
    endtask

    task automatic doClear();
        clearScore = 1'b1;
        @(negedge clock);
        clearScore = 1'b0;
        modelReset();
    endtask

    initial begin
        bit eh, em, ok;
        int timeouts;
        int extra;
        int beats;
        logic [2:0] e, a, b;
        int ns;

        for (int i = 0; i < 8; i++)
            vecs.push_back('{3'd3, 1, 3'd3, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 0, 3'd0, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{3'd0, 1, 3'd4, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{3'd0, 0, 3'd0, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 2, 3'd2, 3'd3, 1'b0, 1'b1});
        vecs.push_back('{3'd6, 2, 3'd6, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{3'd7, 1, 3'd7, 3'd0, 1'b1, 1'b0});

        modelReset();
        repeat (2) @(negedge clock);
        chk("reset score", 32'(score), 32'd0);
        chk("reset mult", 32'(multiplier), 32'd1);
        chk("reset bcdValid", 32'(bcdValid), 32'd0);
        chk("reset bcd", 32'(scoreBcd), 32'd0);
        chk("reset hitmiss", 32'({hit, miss}), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        doClear();
        chk("clear bcdValid", 32'(bcdValid), 32'd1);

        foreach (vecs[i]) begin
            applyBeat(vecs[i].exp, vecs[i].ns, vecs[i].n1, vecs[i].n2);
            modelBeat(vecs[i].exp, vecs[i].ns > 0, vecs[i].n1, eh, em);
            chk($sformatf("tbl%0d hit", i), 32'(hit), 32'(vecs[i].eHit));
            chk($sformatf("tbl%0d miss", i), 32'(miss), 32'(vecs[i].eMiss));
            chk($sformatf("tbl%0d bcdlow", i), 32'(bcdValid), 32'd0);
            checkState($sformatf("tbl%0d", i));
            checkBcd($sformatf("tbl%0d", i));
            if (i == 7) begin
                chk("streak8 bcd", 32'(scoreBcd), 32'h00090);
                chk("streak8 mult", 32'(multiplier), 32'd2);
            end
        end

        // coincident strike belongs to the following beat
        doClear();
        playerValid = 1'b1;
        playerNote = 3'd3;
        addScore = 1'b1;
        expectedNote = 3'd3;
        @(negedge clock);
        playerValid = 1'b0;
        addScore = 1'b0;
        @(negedge clock);
        modelBeat(3'd3, 1'b0, 3'd0, eh, em);
        chk("coinc miss", 32'(miss), 32'd1);
        checkBcd("coinc a");
        applyBeat(3'd3, 0, 3'd0, 3'd0);
        modelBeat(3'd3, 1'b1, 3'd3, eh, em);
        chk("coinc next hit", 32'(hit), 32'd1);
        checkState("coinc");
        checkBcd("coinc b");

        // addScore during conversion is held as pending
        doClear();
        applyBeat(3'd3, 1, 3'd3, 3'd0);
        modelBeat(3'd3, 1'b1, 3'd3, eh, em);
        chk("pend first hit", 32'(hit), 32'd1);
        repeat (2) @(negedge clock);
        strike(3'd5);
        addScore = 1'b1;
        expectedNote = 3'd5;
        @(negedge clock);
        addScore = 1'b0;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            if (hit) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        modelBeat(3'd5, 1'b1, 3'd5, eh, em);
        chk("pend second hit", 32'(ok), 32'd1);
        checkState("pend");
        checkBcd("pend");

        // reset in the middle of a conversion
        applyBeat(3'd2, 1, 3'd2, 3'd0);
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("mid rst score", 32'(score), 32'd0);
        chk("mid rst streak", 32'(streak), 32'd0);
        chk("mid rst mult", 32'(multiplier), 32'd1);
        chk("mid rst bcdValid", 32'(bcdValid), 32'd0);
        chk("mid rst bcd", 32'(scoreBcd), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        modelReset();
        @(negedge clock);

        // songDone blocks judging
        doClear();
        songDone = 1'b1;
        applyBeat(3'd3, 1, 3'd3, 3'd0);
        @(negedge clock);
        chk("songDone no judge", 32'({hit, miss}), 32'd0);
        chk("songDone bcdValid", 32'(bcdValid), 32'd1);
        chk("songDone score", 32'(score), 32'd0);
        songDone = 1'b0;

        // random beats against the model
        doClear();
        for (int r = 0; r < 40; r++) begin
            e = 3'($urandom_range(0, 7));
            ns = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) == 1) ? e : 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            applyBeat(e, ns, a, b);
            modelBeat(e, ns > 0, a, eh, em);
            chk($sformatf("rnd%0d hit", r), 32'(hit), 32'(eh));
            chk($sformatf("rnd%0d miss", r), 32'(miss), 32'(em));
            checkState($sformatf("rnd%0d", r));
            checkBcd($sformatf("rnd%0d", r));
        end

        // saturation at the top of the score range
        doClear();
        timeouts = 0;
        extra = 0;
        beats = 0;
        while (extra < 3 && beats < 2000) begin
            applyBeat(3'd3, 1, 3'd3, 3'd0);
            modelBeat(3'd3, 1'b1, 3'd3, eh, em);
            waitValid(ok);
            if (!ok) timeouts++;
            if (mScore == 65535) extra++;
            beats++;
        end
        chk("sat timeouts", 32'(timeouts), 32'd0);
        chk("sat score", 32'(score), 32'd65535);
        chk("sat bcd", 32'(scoreBcd), 32'h65535);
        checkState("sat");

        // clear wins over a simultaneous addScore
        strike(3'd3);
        clearScore = 1'b1;
        addScore = 1'b1;
        expectedNote = 3'd3;
        @(negedge clock);
        clearScore = 1'b0;
        addScore = 1'b0;
        modelReset();
        chk("clr+add bcdValid", 32'(bcdValid), 32'd1);
        chk("clr+add bcd", 32'(scoreBcd), 32'd0);
        checkState("clr+add");
        @(negedge clock);
        chk("clr+add no judge a", 32'({hit, miss}), 32'd0);
        @(negedge clock);
        chk("clr+add no judge b", 32'({hit, miss}), 32'd0);
        chk("clr+add still valid", 32'(bcdValid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
